hs_rr_merge_arbiter: RTL and testbench

- Shares one downstream handshake consumer (an async_operator input or the output stage) among N_SRC upstream handshake providers.
- Round-robin scheduled; each source has an enable bit.
- Buffers exactly one word and tags it with its source index.
- Per-source request timeout: a stalled producer cannot starve the others.

---
 rtl/hs_rr_merge_arbiter_pkg.sv | 8 +
 rtl/hs_rr_merge_arbiter_rr_next_pick.sv | 25 ++
 rtl/hs_rr_merge_arbiter.sv | 122 ++++++++++++
 tb/tb_hs_rr_merge_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hs_rr_merge_arbiter_pkg.sv
// hs_arb_pkg: shared state type, counter width and index-width helper for the merge arbiter
package hs_arb_pkg;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {IDLE, REQ, DRAIN, HOLD, ACK} arb_state_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hs_rr_merge_arbiter_rr_next_pick.sv
// rr_next_pick: first enabled index at or after ptr, wrapping modulo N
module rr_next_pick import hs_arb_pkg::*; #(
  parameter int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] en_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] g_o,
  output logic         found_o
);
  logic [W-1:0] idx;
  // scan from farthest to nearest so the candidate closest to ptr is the one left standing
  always_comb begin
    g_o = '0;
    found_o = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (en_i[idx]) begin
        g_o = idx;
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hs_rr_merge_arbiter.sv
// hs_rr_merge_arbiter: round-robin merge of N handshake sources into one buffered, source-tagged downstream word
module hs_rr_merge_arbiter import hs_arb_pkg::*; #(
  parameter int N_SRC = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 16,
  localparam int SRC_W = clog2_min1(N_SRC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            en,
  output logic [N_SRC-1:0]            src_req,
  input  logic [N_SRC-1:0]            src_ack,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_din,
  input  logic                        dst_req,
  output logic                        dst_ack,
  output logic [DATA_WIDTH-1:0]       dst_dout,
  output logic [SRC_W-1:0]            dst_src,
  output logic [CNT_W-1:0]            xfer_cnt,
  output logic [CNT_W-1:0]            tmo_cnt
);
  arb_state_e state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d, g_q, g_d, src_q, src_d, pick, g_nxt;
  logic [CNT_W-1:0] wcnt_q, wcnt_d, xfer_q, xfer_d, tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic found, ack_g, tmo_hit;

  rr_next_pick #(.N(N_SRC)) u_pick (
    .en_i   (en),
    .ptr_i  (ptr_q),
    .g_o    (pick),
    .found_o(found)
  );

  assign ack_g = src_ack[g_q];
  assign tmo_hit = (TIMEOUT > 0) && (wcnt_q == CNT_W'(TIMEOUT - 1));
  assign g_nxt = (g_q == SRC_W'(N_SRC - 1)) ? '0 : g_q + 1'b1;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state; an ack always beats a coinciding timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = found ? REQ : IDLE;
      REQ:     state_d = ack_g ? HOLD : (tmo_hit ? DRAIN : REQ);
      DRAIN:   state_d = ack_g ? HOLD : IDLE;
      HOLD:    state_d = dst_req ? ACK : HOLD;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state; only the granted source ever sees a request
  always_comb begin
    src_req = (state_q == REQ) ? (N_SRC'(1) << g_q) : '0;
    dst_ack = (state_q == ACK);
  end

  // datapath next values: grant latch, wait counter, capture buffer, statistics, rotation pointer
  always_comb begin
    ptr_d = ptr_q;
    g_d = g_q;
    wcnt_d = wcnt_q;
    dout_d = dout_q;
    src_d = src_q;
    xfer_d = xfer_q;
    tmo_d = tmo_q;
    unique case (state_q)
      IDLE: begin
        g_d = found ? pick : g_q;
        wcnt_d = '0;
      end
      REQ: begin
        dout_d = ack_g ? src_din[g_q*DATA_WIDTH +: DATA_WIDTH] : dout_q;
        src_d = ack_g ? g_q : src_q;
        tmo_d = (!ack_g && tmo_hit) ? tmo_q + 1'b1 : tmo_q;
        wcnt_d = (!ack_g && !tmo_hit) ? wcnt_q + 1'b1 : wcnt_q;
      end
      DRAIN: begin
        dout_d = ack_g ? src_din[g_q*DATA_WIDTH +: DATA_WIDTH] : dout_q;
        src_d = ack_g ? g_q : src_q;
        tmo_d = ack_g ? tmo_q - 1'b1 : tmo_q;
        ptr_d = ack_g ? ptr_q : g_nxt;
      end
      ACK: begin
        xfer_d = xfer_q + 1'b1;
        ptr_d = g_nxt;
      end
      default: ;
    endcase
  end

  // datapath registers; reset discards any buffered word
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      g_q <= '0;
      wcnt_q <= '0;
      dout_q <= '0;
      src_q <= '0;
      xfer_q <= '0;
      tmo_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      g_q <= g_d;
      wcnt_q <= wcnt_d;
      dout_q <= dout_d;
      src_q <= src_d;
      xfer_q <= xfer_d;
      tmo_q <= tmo_d;
    end
  end

  assign dst_dout = dout_q;
  assign dst_src = src_q;
  assign xfer_cnt = xfer_q;
  assign tmo_cnt = tmo_q;
endmodule

// File: tb/tb_hs_rr_merge_arbiter.sv
// tb_hs_rr_merge_arbiter: directed checks of rotation, enables, timeout, drain capture, backpressure and reset
module tb_hs_rr_merge_arbiter;
  logic clk = 1'b0, rst, dst_req, dst_ack;
  logic [3:0] en, src_req, src_ack, auto_ack, force_ack, fix;
  logic [127:0] src_din;
  logic [31:0] dst_dout, xfer_cnt, tmo_cnt;
  logic [1:0] dst_src;
  logic [31:0] dval [4];
  int k [4] = '{0, 0, 0, 0};
  int total = 0, bad = 0, n;
  bit saw13;
  int lsrc[$], ldat[$];
  int es1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int ed1 [8] = '{0, 10, 20, 30, 1, 11, 21, 31};
  int es2 [4] = '{0, 2, 0, 2};
  int ed2 [4] = '{2, 22, 3, 23};

  hs_rr_merge_arbiter #(.N_SRC(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .src_req(src_req), .src_ack(src_ack), .src_din(src_din),
    .dst_req(dst_req), .dst_ack(dst_ack), .dst_dout(dst_dout), .dst_src(dst_src),
    .xfer_cnt(xfer_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  assign src_ack = (src_req & auto_ack) | force_ack;

  always_comb begin
    src_din = '0;
    for (int i = 0; i < 4; i++) src_din[i*32 +: 32] = fix[i] ? dval[i] : 32'(10 * i + k[i]);
  end

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (!rst && src_req[i] && src_ack[i] && !fix[i]) k[i] <= k[i] + 1;

  always @(negedge clk) begin
    if (dst_ack) begin
      lsrc.push_back(int'(dst_src));
      ldat.push_back(int'(dst_dout));
    end
    if (src_req[1] || src_req[3]) saw13 = 1'b1;
    total++;
    assert ($countones(src_req) <= 1) else begin
      bad++;
      $error("FAIL onehot: src_req=%b want at most one bit", src_req);
    end
  end

  task automatic tick(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; dst_req = 1'b0; auto_ack = '0; force_ack = '0; fix = '0;
    dval = '{32'h0, 32'h0, 32'h0, 32'h0};
    tick(3);
    chk("rst_src_req", 32'(src_req), 0);
    chk("rst_dst_ack", 32'(dst_ack), 0);
    chk("rst_dout", dst_dout, 0);
    chk("rst_dsrc", 32'(dst_src), 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_tmo", tmo_cnt, 0);
    // full rotation, all sources enabled and responsive
    rst = 1'b0; en = 4'b1111; auto_ack = 4'b1111; dst_req = 1'b1;
    for (int i = 0; i < 200 && xfer_cnt != 8; i++) tick(1);
    en = '0;
    chk("t1_xfer", xfer_cnt, 8);
    chk("t1_len", lsrc.size(), 8);
    for (int j = 0; j < 8; j++) begin
      chk("t1_src", lsrc[j], es1[j]);
      chk("t1_dat", ldat[j], ed1[j]);
    end
    tick(5);
    chk("t1_idle", 32'(src_req), 0);
    // sparse enable mask
    lsrc.delete(); ldat.delete(); saw13 = 1'b0; en = 4'b0101;
    for (int i = 0; i < 200 && xfer_cnt != 12; i++) tick(1);
    en = '0;
    chk("t2_xfer", xfer_cnt, 12);
    chk("t2_len", lsrc.size(), 4);
    for (int j = 0; j < 4; j++) begin
      chk("t2_src", lsrc[j], es2[j]);
      chk("t2_dat", ldat[j], ed2[j]);
    end
    chk("t2_no13", 32'(saw13), 0);
    tick(10);
    chk("t2_off_req", 32'(src_req), 0);
    chk("t2_off_xfer", xfer_cnt, 12);
    // silent source 1 times out, source 2 next
    lsrc.delete(); ldat.delete(); en = 4'b0110; auto_ack = 4'b1101;
    for (int i = 0; i < 20 && !src_req[1]; i++) tick(1);
    n = 0;
    for (int i = 0; i < 40 && src_req[1]; i++) begin n++; tick(1); end
    chk("t3_reqlen", n, 16);
    chk("t3_drain_req", 32'(src_req), 0);
    chk("t3_tmo", tmo_cnt, 1);
    for (int i = 0; i < 50 && xfer_cnt != 13; i++) tick(1);
    en = '0;
    chk("t3_xfer", xfer_cnt, 13);
    chk("t3_len", lsrc.size(), 1);
    chk("t3_src", lsrc[0], 2);
    chk("t3_dat", ldat[0], 24);
    chk("t3_tmo2", tmo_cnt, 1);
    // late ack in the drain cycle is accepted and the timeout retracted
    lsrc.delete(); ldat.delete(); en = 4'b0010;
    for (int i = 0; i < 20 && !src_req[1]; i++) tick(1);
    n = 0;
    for (int i = 0; i < 40 && src_req[1]; i++) begin n++; tick(1); end
    chk("t4_reqlen", n, 16);
    chk("t4_tmo_drain", tmo_cnt, 2);
    fix[1] = 1'b1; dval[1] = 32'hABCD; force_ack = 4'b0010;
    tick(1);
    force_ack = '0;
    chk("t4_tmo_back", tmo_cnt, 1);
    chk("t4_dout", dst_dout, 32'hABCD);
    chk("t4_dsrc", 32'(dst_src), 1);
    for (int i = 0; i < 20 && xfer_cnt != 14; i++) tick(1);
    en = '0; fix[1] = 1'b0;
    chk("t4_xfer", xfer_cnt, 14);
    chk("t4_len", lsrc.size(), 1);
    chk("t4_src", lsrc[0], 1);
    chk("t4_dat", ldat[0], 32'hABCD);
    // downstream backpressure holds the word
    lsrc.delete(); ldat.delete(); dst_req = 1'b0; auto_ack = 4'b1111; fix[0] = 1'b1; dval[0] = 32'h55; en = 4'b0001;
    for (int i = 0; i < 20 && !src_req[0]; i++) tick(1);
    tick(1);
    en = 4'b1111;
    for (int i = 0; i < 50; i++) begin
      chk("t5_req", 32'(src_req), 0);
      chk("t5_ack", 32'(dst_ack), 0);
      chk("t5_dout", dst_dout, 32'h55);
      tick(1);
    end
    dst_req = 1'b1;
    tick(1);
    en = '0;
    chk("t5_ack_hi", 32'(dst_ack), 1);
    chk("t5_ack_dout", dst_dout, 32'h55);
    chk("t5_ack_dsrc", 32'(dst_src), 0);
    tick(1);
    fix[0] = 1'b0;
    chk("t5_ack_lo", 32'(dst_ack), 0);
    chk("t5_xfer", xfer_cnt, 15);
    chk("t5_len", lsrc.size(), 1);
    // reset mid-request with a stray ack
    lsrc.delete(); ldat.delete(); auto_ack = 4'b1011; en = 4'b0100;
    for (int i = 0; i < 20 && !src_req[2]; i++) tick(1);
    chk("t6_req2", 32'(src_req), 4);
    tick(2);
    rst = 1'b1; force_ack = 4'b0100;
    tick(1);
    chk("t6_src_req", 32'(src_req), 0);
    chk("t6_dst_ack", 32'(dst_ack), 0);
    chk("t6_dout", dst_dout, 0);
    chk("t6_dsrc", 32'(dst_src), 0);
    chk("t6_xfer", xfer_cnt, 0);
    chk("t6_tmo", tmo_cnt, 0);
    rst = 1'b0; force_ack = '0; en = 4'b1111; auto_ack = 4'b1111;
    for (int i = 0; i < 20 && src_req == 0; i++) tick(1);
    chk("t6_first", 32'(src_req), 1);
    for (int i = 0; i < 20 && xfer_cnt != 1; i++) tick(1);
    en = '0;
    chk("t6_xfer1", xfer_cnt, 1);
    chk("t6_len", lsrc.size(), 1);
    chk("t6_src", lsrc[0], 0);
    chk("t6_dat", ldat[0], 4);
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
